pc_next_gen: RTL and testbench
==============================

PC_NEXT_GEN -- requirements
Module: pc_next_gen

Interface
REQ-001 Parameters SHALL be, one per line:
- XLEN, 32, PC/target width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- BTB_DEPTH, 16, BTB entries; power of two, at least 2.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk in 1: single clock; all state updates on rising edge.
- rst_n in 1: synchronous, active-low reset.
- stall in 1: hold PC (fetch backpressure from pipeline).
- fetch_ready in 1: consumer accepts fetch_pc.
- fetch_valid out 1: fetch_pc valid.
- fetch_pc out XLEN: PC being fetched.
- fetch_pred_taken out 1: BTB predicted taken for fetch_pc.
- fetch_pred_target out XLEN: predicted target (PC+4 when not taken).
- ex_valid in 1: resolved control-flow info valid.
- ex_pc in XLEN: PC of resolved instruction.
- ex_branch in 1: conditional branch.
- ex_jump in 1: JAL/JALR.
- ex_op in 7: opcode.
- ex_taken in 1: branch condition true.
- ex_pc_branch in XLEN: PC-relative target.
- ex_jalr_target in XLEN: register target.
- ex_pred_taken in 1: prediction carried down the pipe.
- ex_pred_target in XLEN: predicted target carried down the pipe.
- trap_valid in 1: trap or exception redirect.
- trap_vec in XLEN: trap vector.
- flush out 1: one-cycle pulse, squash younger instructions.

Function
REQ-003 The resolved target SHALL be ex_jalr_target when ex_jump=1 and ex_op=7'b1100111; otherwise it SHALL be ex_pc_branch.
REQ-004 The actual next PC SHALL be the resolved target when ex_jump=1 or (ex_branch=1 and ex_taken=1); otherwise it SHALL be ex_pc+4, modulo 2^XLEN.
REQ-005 The predicted next PC SHALL be ex_pred_target when ex_pred_taken=1, else ex_pc+4. A mispredict SHALL be asserted when ex_valid=1 and the actual next PC differs from the predicted next PC.
REQ-006 Redirect priority SHALL be: trap_valid (PC<=trap_vec), then mispredict (PC<=actual next), then normal advance. A redirect SHALL ignore stall and fetch_ready.
REQ-007 flush SHALL be registered and SHALL be high exactly one cycle, the cycle after any redirect.
REQ-008 The FSM SHALL have states BOOT, RUN and BUBBLE.
- BOOT: fetch_valid=0; next state RUN.
- RUN: fetch_valid=1; a redirect goes to BUBBLE.
- BUBBLE: fetch_valid=0; PC holds the redirect target; next state RUN, or BUBBLE again if another redirect arrives.
REQ-009 In RUN with no redirect, the PC SHALL advance to fetch_pred_target only when fetch_valid & fetch_ready & !stall; otherwise the PC SHALL hold.
REQ-010 PC+4 SHALL wrap modulo 2^XLEN with no error indication.

Reset
REQ-011 With rst_n=0 at a clock edge:
- PC<=RESET_PC.
- FSM<=BOOT.
- flush<=0.
- fetch_valid=0.
- all BTB valid bits<=0.
REQ-012 Reset SHALL override trap_valid, mispredict and stall, including in the middle of a redirect.

Configuration
REQ-013 With PCSEL_BTB_EN defined, the block SHALL contain a BTB_DEPTH-entry BTB.
- Index: fetch_pc[log2(BTB_DEPTH)+1:2].
- Entry: tag (the remaining upper PC bits), valid bit, target, 2-bit saturating counter.
- Prediction: fetch_pred_taken = hit & counter>=2.
REQ-014 BTB update SHALL occur when ex_valid & (ex_branch|ex_jump), and the write SHALL be visible the next cycle. The fetch read in the same cycle SHALL return the pre-update contents.
- Miss and taken: allocate with counter=2'b10 (2'b11 for jumps).
- Miss and not-taken: no allocation.
- Hit: counter increments/decrements with saturation; target is rewritten when taken; jumps force counter=2'b11.
REQ-015 Without PCSEL_BTB_EN, no BTB storage SHALL exist. fetch_pred_taken SHALL be 0 and fetch_pred_target SHALL be fetch_pc+4. All other behaviour is unchanged.

Structure
REQ-016 Package pcsel_pkg SHALL hold OP_JALR=7'b1100111, the FSM state enum, and the counter encodings (SNT=00, WNT=01, WT=10, ST=11).
REQ-017 The BTB SHALL be a sub-module pc_btb, instantiated only under PCSEL_BTB_EN.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- Reset, then release rst_n: fetch_valid=0 for 1 cycle, then fetch_pc=0x0 and 0x4, 0x8 on successive accepted cycles; hold while stall=1.
- ex_jump=1, ex_op=0x67, ex_jalr_target=0x200, ex_pred_taken=0: flush pulses, BUBBLE lasts 1 cycle, then fetch_pc=0x200.
- trap_valid=1 (trap_vec=0x100) in the same cycle as a mispredict to 0x300: fetch_pc=0x100 after the bubble.
- With PCSEL_BTB_EN, branch at 0x40 taken to 0x80 twice: third fetch of 0x40 gives pred_taken=1 and next fetch_pc=0x80 with no flush.
- Then the same branch not-taken twice: counter goes 11->10->01, and fetch of 0x40 predicts not-taken.
- fetch_pc=0xFFFF_FFFC advanced normally: next fetch_pc=0x0000_0000.

Source files
------------

// File: rtl/pcsel_pkg.sv
// Shared definitions for the PC-select block: JALR opcode, FSM states and
// 2-bit branch counter encodings with a saturating step helper.
package pcsel_pkg;

  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    BUBBLE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
    logic [1:0] cv;
    cv = c;
    if (taken) begin
      return (c == ST) ? ST : ctr_e'(cv + 2'd1);
    end
    return (c == SNT) ? SNT : ctr_e'(cv - 2'd1);
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on registered contents, so same-cycle updates stay invisible.
module pc_btb
  import pcsel_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_jump_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned TAGW = XLEN - IDXW - 2;

  logic [DEPTH-1:0] valid_q;
  logic [TAGW-1:0]  tag_q    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  ctr_e             ctr_q    [DEPTH];

  logic [IDXW-1:0] rd_idx;
  logic [IDXW-1:0] wr_idx;
  logic [TAGW-1:0] rd_tag;
  logic [TAGW-1:0] wr_tag;
  logic            rd_hit;
  logic            wr_hit;

  assign rd_idx = fetch_pc_i[IDXW+1:2];
  assign rd_tag = fetch_pc_i[XLEN-1:IDXW+2];
  assign wr_idx = upd_pc_i[IDXW+1:2];
  assign wr_tag = upd_pc_i[XLEN-1:IDXW+2];

  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  assign pred_taken_o  = rd_hit && ctr_q[rd_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[rd_idx] : fetch_pc_i + XLEN'(4);

  // Only valid bits are reset; tag/target/counter are don't-care until allocated.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (upd_i) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= upd_jump_i ? ST : ctr_step(ctr_q[wr_idx], upd_taken_i);
        if (upd_taken_i) begin
          target_q[wr_idx] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= upd_target_i;
        ctr_q[wr_idx]    <= upd_jump_i ? ST : WT;
      end
    end
  end

endmodule

// File: rtl/pc_next_gen.sv
// Next-PC generator: trap/mispredict redirect, fetch FSM and optional BTB
// prediction (enabled with macro PCSEL_BTB_EN).
module pc_next_gen
  import pcsel_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_pred_taken,
  output logic [XLEN-1:0] fetch_pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic [6:0]      ex_op,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc_branch,
  input  logic [XLEN-1:0] ex_jalr_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic            flush
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q;

  logic [XLEN-1:0] resolved_target;
  logic [XLEN-1:0] ex_pc_plus4;
  logic [XLEN-1:0] actual_next;
  logic [XLEN-1:0] predicted_next;
  logic            ex_cf_taken;
  logic            mispredict;
  logic            redirect;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  assign resolved_target = (ex_jump && (ex_op == OP_JALR)) ? ex_jalr_target : ex_pc_branch;
  assign ex_pc_plus4     = ex_pc + XLEN'(4);
  assign ex_cf_taken     = ex_jump || (ex_branch && ex_taken);
  assign actual_next     = ex_cf_taken ? resolved_target : ex_pc_plus4;
  assign predicted_next  = ex_pred_taken ? ex_pred_target : ex_pc_plus4;
  assign mispredict      = ex_valid && (actual_next != predicted_next);
  assign redirect        = trap_valid || mispredict;

`ifdef PCSEL_BTB_EN
  pc_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .fetch_pc_i    (pc_q),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_i         (ex_valid && (ex_branch || ex_jump)),
    .upd_pc_i      (ex_pc),
    .upd_jump_i    (ex_jump),
    .upd_taken_i   (ex_cf_taken),
    .upd_target_i  (resolved_target)
  );
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_q + XLEN'(4);
`endif

  // Redirect is applied last so it overrides both the FSM step and stall/ready.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_valid = 1'b0;
    unique case (state_q)
      BOOT:   state_d = RUN;
      RUN: begin
        fetch_valid = 1'b1;
        if (fetch_ready && !stall) begin
          pc_d = pred_target;
        end
      end
      BUBBLE: state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redirect) begin
      state_d = BUBBLE;
      pc_d    = trap_valid ? trap_vec : actual_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= redirect;
    end
  end

  assign fetch_pc          = pc_q;
  assign fetch_pred_taken  = pred_taken;
  assign fetch_pred_target = pred_target;
  assign flush             = flush_q;

endmodule

// File: tb/tb_pc_next_gen.sv
// Self-checking bench for pc_next_gen: directed scenarios plus randomized
// traffic checked against a behavioural next-PC/BTB model.
module tb_pc_next_gen;

  logic        clk = 1'b0;
  logic        rst_n, stall, fetch_ready;
  logic        fetch_valid, fetch_pred_taken, flush;
  logic [31:0] fetch_pc, fetch_pred_target;
  logic        ex_valid, ex_branch, ex_jump, ex_taken, ex_pred_taken, trap_valid;
  logic [6:0]  ex_op;
  logic [31:0] ex_pc, ex_pc_branch, ex_jalr_target, ex_pred_target, trap_vec;

  int passed = 0;
  int total  = 0;

  // Model state: what the outputs should be after the most recent clock edge.
  bit [31:0] m_pc;
  bit        m_fv, m_flush;
  bit        mb_v   [16];
  bit [31:0] mb_pc  [16];
  bit [31:0] mb_tgt [16];
  int        mb_ctr [16];

  pc_next_gen #(.XLEN(32), .RESET_PC(32'h0), .BTB_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_pred_taken(fetch_pred_taken), .fetch_pred_target(fetch_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_op(ex_op), .ex_taken(ex_taken), .ex_pc_branch(ex_pc_branch),
    .ex_jalr_target(ex_jalr_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .trap_valid(trap_valid), .trap_vec(trap_vec),
    .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic void model_pred(input bit [31:0] pc, output bit tk, output bit [31:0] tg);
    tk = 1'b0;
    tg = pc + 32'd4;
`ifdef PCSEL_BTB_EN
    begin
      int idx;
      idx = int'((pc >> 2) % 16);
      if (mb_v[idx] && (mb_pc[idx] >> 2) == (pc >> 2) && mb_ctr[idx] >= 2) begin
        tk = 1'b1;
        tg = mb_tgt[idx];
      end
    end
`endif
  endfunction

  task automatic idle_inputs();
    stall = 0; fetch_ready = 1; ex_valid = 0; ex_pc = 0; ex_branch = 0; ex_jump = 0;
    ex_op = 7'h63; ex_taken = 0; ex_pc_branch = 0; ex_jalr_target = 0;
    ex_pred_taken = 0; ex_pred_target = 0; trap_valid = 0; trap_vec = 0;
  endtask

  // Advance model by one clock from current inputs, then clock the DUT.
  task automatic cycle();
    bit        ptk, taken, mis;
    bit [31:0] ptg, resolved, actual, predicted, npc;
    bit        nfv, nflush;
    model_pred(m_pc, ptk, ptg);
    resolved  = (ex_jump && ex_op == 7'h67) ? ex_jalr_target : ex_pc_branch;
    taken     = ex_jump || (ex_branch && ex_taken);
    actual    = taken ? resolved : ex_pc + 32'd4;
    predicted = ex_pred_taken ? ex_pred_target : ex_pc + 32'd4;
    mis       = ex_valid && (actual != predicted);
    if (!rst_n) begin
      npc = 32'h0; nfv = 0; nflush = 0;
      for (int i = 0; i < 16; i++) mb_v[i] = 0;
    end else begin
      if (trap_valid)                            npc = trap_vec;
      else if (mis)                              npc = actual;
      else if (m_fv && fetch_ready && !stall)    npc = ptg;
      else                                       npc = m_pc;
      nfv    = !(trap_valid || mis);
      nflush = trap_valid || mis;
      if (ex_valid && (ex_branch || ex_jump)) begin
        int idx;
        idx = int'((ex_pc >> 2) % 16);
        if (mb_v[idx] && (mb_pc[idx] >> 2) == (ex_pc >> 2)) begin
          if (ex_jump)    mb_ctr[idx] = 3;
          else if (taken) mb_ctr[idx] = (mb_ctr[idx] < 3) ? mb_ctr[idx] + 1 : 3;
          else            mb_ctr[idx] = (mb_ctr[idx] > 0) ? mb_ctr[idx] - 1 : 0;
          if (taken) mb_tgt[idx] = resolved;
        end else if (taken) begin
          mb_v[idx] = 1; mb_pc[idx] = ex_pc; mb_tgt[idx] = resolved;
          mb_ctr[idx] = ex_jump ? 3 : 2;
        end
      end
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_fv = nfv; m_flush = nflush;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; stall = 1; trap_valid = 1; trap_vec = 32'h500;
    ex_valid = 1; ex_jump = 1; ex_op = 7'h67; ex_jalr_target = 32'h600;
    cycle(); cycle();
    total++; if (fetch_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", fetch_valid); else passed++;
    total++; if (fetch_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", fetch_pc); else passed++;
    total++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush); else passed++;
    idle_inputs(); rst_n = 1;
    cycle();
    total++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0) $display("FAIL boot_run: got fv=%b pc=%h want 1/0", fetch_valid, fetch_pc); else passed++;
    cycle();
    total++; if (fetch_pc !== 32'h4) $display("FAIL adv_4: got %h want 4", fetch_pc); else passed++;
    cycle();
    total++; if (fetch_pc !== 32'h8) $display("FAIL adv_8: got %h want 8", fetch_pc); else passed++;
    total++; if (fetch_pred_target !== 32'hC) $display("FAIL pred_tgt_8: got %h want c", fetch_pred_target); else passed++;
    stall = 1; cycle(); cycle();
    total++; if (fetch_pc !== 32'h8 || fetch_valid !== 1'b1) $display("FAIL stall_hold: got pc=%h fv=%b want 8/1", fetch_pc, fetch_valid); else passed++;
    stall = 0; fetch_ready = 0; cycle();
    total++; if (fetch_pc !== 32'h8) $display("FAIL notready_hold: got %h want 8", fetch_pc); else passed++;
    fetch_ready = 1; cycle();
    total++; if (fetch_pc !== 32'hC) $display("FAIL adv_c: got %h want c", fetch_pc); else passed++;
  endtask

  task automatic test_jalr_redirect();
    idle_inputs();
    ex_valid = 1; ex_jump = 1; ex_op = 7'h67; ex_pc = 32'h8; ex_jalr_target = 32'h200;
    ex_pc_branch = 32'h999; ex_pred_taken = 0; stall = 1;
    cycle(); idle_inputs();
    total++; if (flush !== 1'b1 || fetch_valid !== 1'b0) $display("FAIL jalr_bubble: got flush=%b fv=%b want 1/0", flush, fetch_valid); else passed++;
    cycle();
    total++; if (flush !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== 32'h200) $display("FAIL jalr_target: got flush=%b fv=%b pc=%h want 0/1/200", flush, fetch_valid, fetch_pc); else passed++;
    cycle();
    total++; if (fetch_pc !== 32'h204) $display("FAIL jalr_next: got %h want 204", fetch_pc); else passed++;
  endtask

  task automatic test_trap_priority();
    idle_inputs();
    ex_valid = 1; ex_branch = 1; ex_taken = 1; ex_pc = 32'h204; ex_pc_branch = 32'h300;
    trap_valid = 1; trap_vec = 32'h100;
    cycle(); idle_inputs();
    total++; if (flush !== 1'b1 || fetch_valid !== 1'b0) $display("FAIL trap_bubble: got flush=%b fv=%b want 1/0", flush, fetch_valid); else passed++;
    cycle();
    total++; if (fetch_pc !== 32'h100 || fetch_valid !== 1'b1) $display("FAIL trap_prio: got pc=%h fv=%b want 100/1", fetch_pc, fetch_valid); else passed++;
  endtask

  task automatic test_reset_mid_redirect();
    idle_inputs();
    trap_valid = 1; trap_vec = 32'h700;
    cycle();
    rst_n = 0; trap_valid = 1; trap_vec = 32'h800;
    cycle();
    total++; if (fetch_pc !== 32'h0 || flush !== 1'b0 || fetch_valid !== 1'b0) $display("FAIL reset_mid: got pc=%h flush=%b fv=%b want 0/0/0", fetch_pc, flush, fetch_valid); else passed++;
    idle_inputs(); rst_n = 1;
    cycle();
    total++; if (fetch_pc !== 32'h0 || fetch_valid !== 1'b1) $display("FAIL reset_mid_run: got pc=%h fv=%b want 0/1", fetch_pc, fetch_valid); else passed++;
  endtask

  task automatic test_wrap();
    idle_inputs();
    trap_valid = 1; trap_vec = 32'hFFFF_FFFC;
    cycle(); idle_inputs(); cycle();
    total++; if (fetch_pc !== 32'hFFFF_FFFC || fetch_pred_target !== 32'h0) $display("FAIL wrap_pre: got pc=%h tgt=%h want fffffffc/0", fetch_pc, fetch_pred_target); else passed++;
    cycle();
    total++; if (fetch_pc !== 32'h0 || flush !== 1'b0 || fetch_valid !== 1'b1) $display("FAIL wrap: got pc=%h flush=%b fv=%b want 0/0/1", fetch_pc, flush, fetch_valid); else passed++;
  endtask

`ifdef PCSEL_BTB_EN
  task automatic test_btb();
    idle_inputs();
    trap_valid = 1; trap_vec = 32'h40;
    cycle(); idle_inputs(); stall = 1; cycle();
    total++; if (fetch_pc !== 32'h40 || fetch_pred_taken !== 1'b0) $display("FAIL btb_cold: got pc=%h tk=%b want 40/0", fetch_pc, fetch_pred_taken); else passed++;
    ex_valid = 1; ex_branch = 1; ex_taken = 1; ex_pc = 32'h40; ex_pc_branch = 32'h80;
    ex_pred_taken = 1; ex_pred_target = 32'h80;
    total++; if (fetch_pred_taken !== 1'b0) $display("FAIL btb_same_cycle: got %b want 0", fetch_pred_taken); else passed++;
    cycle(); cycle();
    ex_valid = 0;
    total++; if (fetch_pred_taken !== 1'b1 || fetch_pred_target !== 32'h80) $display("FAIL btb_hit: got tk=%b tgt=%h want 1/80", fetch_pred_taken, fetch_pred_target); else passed++;
    stall = 0; cycle();
    total++; if (fetch_pc !== 32'h80 || flush !== 1'b0) $display("FAIL btb_follow: got pc=%h flush=%b want 80/0", fetch_pc, flush); else passed++;
    idle_inputs(); stall = 1; trap_valid = 1; trap_vec = 32'h40;
    cycle(); trap_valid = 0; cycle();
    ex_valid = 1; ex_branch = 1; ex_taken = 0; ex_pc = 32'h40; ex_pc_branch = 32'h80; ex_pred_taken = 0;
    cycle();
    total++; if (fetch_pred_taken !== 1'b1) $display("FAIL btb_ctr10: got %b want 1", fetch_pred_taken); else passed++;
    cycle(); ex_valid = 0;
    total++; if (fetch_pred_taken !== 1'b0 || fetch_pred_target !== 32'h44) $display("FAIL btb_ctr01: got tk=%b tgt=%h want 0/44", fetch_pred_taken, fetch_pred_target); else passed++;
    stall = 0; cycle();
    total++; if (fetch_pc !== 32'h44 || flush !== 1'b0) $display("FAIL btb_nt_follow: got pc=%h flush=%b want 44/0", fetch_pc, flush); else passed++;
  endtask
`endif

  task automatic test_random();
    bit        ptk, tk;
    bit [31:0] ptg, res;
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      rst_n       = ($urandom_range(0, 99) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      fetch_ready = ($urandom_range(0, 4) != 0);
      trap_valid  = ($urandom_range(0, 19) == 0);
      trap_vec    = {$urandom_range(0, 255), 2'b00};
      ex_valid    = ($urandom_range(0, 2) == 0);
      ex_pc       = {$urandom_range(0, 63), 2'b00};
      ex_branch   = $urandom_range(0, 1);
      ex_jump     = !ex_branch && ($urandom_range(0, 2) == 0);
      ex_op       = $urandom_range(0, 1) ? 7'h67 : 7'h6F;
      ex_taken    = $urandom_range(0, 1);
      ex_pc_branch   = {$urandom_range(0, 255), 2'b00};
      ex_jalr_target = {$urandom_range(0, 255), 2'b00};
      if ($urandom_range(0, 1)) begin
        tk  = ex_jump || (ex_branch && ex_taken);
        res = (ex_jump && ex_op == 7'h67) ? ex_jalr_target : ex_pc_branch;
        ex_pred_taken  = tk;
        ex_pred_target = res;
      end else begin
        ex_pred_taken  = $urandom_range(0, 1);
        ex_pred_target = {$urandom_range(0, 255), 2'b00};
      end
      cycle();
      model_pred(m_pc, ptk, ptg);
      total++; if (fetch_valid !== m_fv) $display("FAIL rnd_fv[%0d]: got %b want %b", n, fetch_valid, m_fv); else passed++;
      total++; if (fetch_pc !== m_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", n, fetch_pc, m_pc); else passed++;
      total++; if (flush !== m_flush) $display("FAIL rnd_flush[%0d]: got %b want %b", n, flush, m_flush); else passed++;
      total++; if (fetch_pred_taken !== ptk || fetch_pred_target !== ptg) $display("FAIL rnd_pred[%0d]: got %b/%h want %b/%h", n, fetch_pred_taken, fetch_pred_target, ptk, ptg); else passed++;
    end
  endtask

  initial begin
    m_pc = 0; m_fv = 0; m_flush = 0;
    for (int i = 0; i < 16; i++) begin
      mb_v[i] = 0; mb_pc[i] = 0; mb_tgt[i] = 0; mb_ctr[i] = 0;
    end
    rst_n = 0;
    test_reset();
    test_jalr_redirect();
    test_trap_priority();
    test_reset_mid_redirect();
`ifdef PCSEL_BTB_EN
    test_btb();
`endif
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
